// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared mode encodings for immediate extension
package imm_ext_pkg;
    typedef enum logic [1:0] {
        MODE_SEXT      = 2'b00,
        MODE_ZEXT      = 2'b01,
        MODE_SEXT_SHL2 = 2'b10,
        MODE_UPPER     = 2'b11
    } imm_mode_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension for the four modes
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  data,
    input  imm_mode_t        mode,
    output logic [OUT_W-1:0] result
);
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;
    assign w_sext  = {{(OUT_W-IN_W){data[IN_W-1]}}, data};
    assign w_zext  = {{(OUT_W-IN_W){1'b0}}, data};
    assign w_upper = {data, {(OUT_W-IN_W){1'b0}}};
    always_comb
        result = mode == MODE_SEXT ? w_sext :
                 mode == MODE_ZEXT ? w_zext :
                 mode == MODE_SEXT_SHL2 ? (w_sext << 2) : w_upper;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate extender behind a 2-entry skid buffer
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);
    if (IN_W < 2 || IN_W >= OUT_W) begin : g_bad_param
        $error("imm_extend_pipe: need 2 <= IN_W < OUT_W");
    end
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_main_data;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic             w_acc;
    logic             w_load;
    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .data   (in_data),
        .mode   (imm_mode_t'(in_mode)),
        .result (w_ext)
    );
    assign w_acc  = in_valid & r_in_ready;
    assign w_load = ~r_main_valid | out_ready;
    // Main register refills from skid first to keep accept order; skid only fills when main is stuck.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b0;
        end else if (w_load) begin
            r_main_valid <= r_skid_valid | w_acc;
            if (r_skid_valid | w_acc)
                r_main_data <= r_skid_valid ? r_skid_data : w_ext;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_ext;
            r_in_ready   <= 1'b0;
        end
    end
    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and scoreboard checks of the immediate extend pipe
module tb_imm_extend_pipe;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [25:0] p_in_data = '0;
    logic [1:0]  p_in_mode = '0;
    logic        p_out_valid;
    logic        p_out_ready = 1'b1;
    logic [31:0] p_out_data;
    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    imm_extend_pipe u_dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    imm_extend_pipe #(.IN_W(26), .OUT_W(32)) u_dut26 (
        .Clk(Clk), .Reset(Reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_data(p_in_data), .in_mode(p_in_mode), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .out_data(p_out_data)
    );

    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
        logic signed [31:0] s;
        s = $signed(d);
        case (m)
            2'd0:    return s;
            2'd1:    return {16'h0000, d};
            2'd2:    return s * 4;
            default: return {d, 16'h0000};
        endcase
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h1234;
        p_in_valid = 1'b1;
        repeat (2) tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got v=%b r=%b d=%h exp v=0 r=0 d=00000000", out_valid, in_ready, out_data);
        end
        total++;
        if (p_out_valid !== 1'b0 || p_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state26 got v=%b r=%b exp v=0 r=0", p_out_valid, p_in_ready);
        end
        Reset = 1'b0;
        in_valid = 1'b0;
        p_in_valid = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_modes;
        logic [31:0] exp_v [4] = '{32'hFFFF8001, 32'h00008001, 32'hFFFE0004, 32'h80010000};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data = 16'h8001;
            in_mode = 2'(k);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k]) begin
                bad++;
                $display("FAIL mode%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_v[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mode_drain got v=%b exp v=0", out_valid);
        end
    endtask

    task automatic test_positive;
        in_valid = 1'b1;
        in_data = 16'h7FFF;
        in_mode = 2'b00;
        tick();
        total++;
        if (out_data !== 32'h00007FFF) begin
            bad++;
            $display("FAIL pos_sext got %h exp 00007fff", out_data);
        end
        in_mode = 2'b10;
        tick();
        total++;
        if (out_data !== 32'h0001FFFC) begin
            bad++;
            $display("FAIL pos_shl2 got %h exp 0001fffc", out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 2'b00;
        in_data = 16'h0001;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_first got v=%b d=%h r=%b exp v=1 d=00000001 r=1", out_valid, out_data, in_ready);
        end
        in_data = 16'h0002;
        tick();
        total++;
        if (in_ready !== 1'b0 || out_data !== 32'h1) begin
            bad++;
            $display("FAIL bp_full got r=%b d=%h exp r=0 d=00000001", in_ready, out_data);
        end
        in_data = 16'h0003;
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1) begin
            bad++;
            $display("FAIL bp_stable got r=%b v=%b d=%h exp r=0 v=1 d=00000001", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_data !== 32'h2 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second got d=%h r=%b exp d=00000002 r=1", out_data, in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h3) begin
            bad++;
            $display("FAIL bp_third got v=%b d=%h exp v=1 d=00000003", out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty got v=%b exp v=0", out_valid);
        end
    endtask

    task automatic test_throughput;
        logic [31:0] q [$];
        int acc = 0;
        int cyc = 0;
        while (acc < 100 && cyc < 2000) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_data = 16'($urandom);
            in_mode = 2'($urandom);
            @(negedge Clk);
            total++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                bad++;
                $display("FAIL tp_flags cyc=%0d got v=%b r=%b held=%0d", cyc, out_valid, in_ready, q.size());
            end
            if (out_valid && out_ready && q.size() != 0) begin
                total++;
                if (out_data !== q[0]) begin
                    bad++;
                    $display("FAIL tp_data cyc=%0d got %h exp %h", cyc, out_data, q[0]);
                end
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_ext(in_data, in_mode));
                acc++;
            end
            cyc++;
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 10) begin
            @(negedge Clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== q[0]) begin
                bad++;
                $display("FAIL tp_drain got v=%b d=%h exp v=1 d=%h", out_valid, out_data, q[0]);
            end
            void'(q.pop_front());
            tick();
            cyc++;
        end
        total++;
        if (acc != 100 || q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL tp_complete got accepts=%0d left=%0d v=%b exp accepts=100 left=0 v=0", acc, q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 2'b01;
        in_data = 16'h00AA;
        tick();
        in_data = 16'h00BB;
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rm_full got r=%b v=%b exp r=0 v=1", in_ready, out_valid);
        end
        Reset = 1'b1;
        in_data = 16'h00CC;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rm_during got v=%b r=%b exp v=0 r=0", out_valid, in_ready);
        end
        Reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rm_after got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rm_stale%0d got v=%b d=%h exp v=0", k, out_valid, out_data);
            end
        end
        in_valid = 1'b1;
        in_data = 16'h0055;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000055) begin
            bad++;
            $display("FAIL rm_fresh got v=%b d=%h exp v=1 d=00000055", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_param;
        p_out_ready = 1'b1;
        p_in_valid = 1'b1;
        p_in_data = 26'h2000000;
        p_in_mode = 2'b00;
        tick();
        total++;
        if (p_out_valid !== 1'b1 || p_out_data !== 32'hFE000000) begin
            bad++;
            $display("FAIL p26_sext got v=%b d=%h exp v=1 d=fe000000", p_out_valid, p_out_data);
        end
        p_in_mode = 2'b01;
        tick();
        p_in_valid = 1'b0;
        total++;
        if (p_out_valid !== 1'b1 || p_out_data !== 32'h02000000) begin
            bad++;
            $display("FAIL p26_zext got v=%b d=%h exp v=1 d=02000000", p_out_valid, p_out_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_modes();
        test_positive();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
